// File: rtl/voting_machine_multi.sv
// Multi-candidate vote counter: one vote per single-button press, multi-press rejection,
// post-press lockout, and frozen tallies with winner/tie/turnout at close of poll.
module voting_machine_multi #(
  parameter int NUM_CAND    = 4,
  parameter int CNT_W       = 8,
  parameter int LOCKOUT_CYC = 16,
  localparam int IDX_W      = $clog2(NUM_CAND),
  localparam int TOT_W      = CNT_W + IDX_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CAND-1:0]       i_candidate,
  input  logic                      i_voting_over,
  output logic [NUM_CAND*CNT_W-1:0] o_counts,
  output logic [TOT_W-1:0]          o_total,
  output logic [IDX_W-1:0]          o_winner,
  output logic                      o_tie,
  output logic                      o_results_valid,
  output logic                      o_vote_ack,
  output logic                      o_invalid,
  output logic                      green,
  output logic                      blue
);

  // state   | meaning
  // VOTE    | poll open, waiting for a press
  // LOCKOUT | press taken, waiting for lockout time and button release
  // FINISH  | poll closed, tallies frozen, results published
  typedef enum logic [1:0] {S_VOTE, S_LOCKOUT, S_FINISH} state_t;

  localparam int TMR_W = $clog2(LOCKOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_END = TMR_W'(LOCKOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [TOT_W-1:0] TOT_MAX = {TOT_W{1'b1}};

  state_t             state, next_state;
  logic [CNT_W-1:0]   tally [NUM_CAND];
  logic [TOT_W-1:0]   total;
  logic [TMR_W-1:0]   timer;

  logic               any_press, one_hot;
  logic               accept, reject, enter_lockout, enter_finish, publish;
  logic [CNT_W-1:0]   best_val;
  logic [IDX_W-1:0]   best_idx;
  logic               best_tie;

  assign any_press = |i_candidate;
  assign one_hot   = any_press && ((i_candidate & (i_candidate - 1'b1)) == '0);

  // state register, with the registered status LEDs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_VOTE;
      green <= 1'b1;
      blue  <= 1'b0;
    end else begin
      state <= next_state;
      green <= (next_state != S_FINISH);
      blue  <= (next_state == S_FINISH);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_VOTE: begin
        if (i_voting_over)  next_state = S_FINISH;
        else if (any_press) next_state = S_LOCKOUT;
      end
      S_LOCKOUT: begin
        if (i_voting_over)                         next_state = S_FINISH;
        else if (timer == TMR_END && !any_press)   next_state = S_VOTE;
      end
      S_FINISH: next_state = S_FINISH;
      default:  next_state = S_VOTE;
    endcase
  end

  always_comb begin
    accept        = 1'b0;
    reject        = 1'b0;
    enter_lockout = 1'b0;
    enter_finish  = 1'b0;
    publish       = 1'b0;
    if (state == S_VOTE && !i_voting_over) begin
      accept = one_hot;
      reject = any_press && !one_hot;
    end
    enter_lockout = (next_state == S_LOCKOUT) && (state != S_LOCKOUT);
    enter_finish  = (next_state == S_FINISH) && (state != S_FINISH);
    publish       = (state == S_FINISH) && !o_results_valid;
  end

  // results are judged on the frozen copy, so they never see a late vote
  always_comb begin
    best_val = o_counts[0 +: CNT_W];
    best_idx = '0;
    best_tie = 1'b0;
    for (int n = 1; n < NUM_CAND; n++) begin
      if (o_counts[n*CNT_W +: CNT_W] > best_val) begin
        best_val = o_counts[n*CNT_W +: CNT_W];
        best_idx = IDX_W'(n);
      end
    end
    for (int n = 0; n < NUM_CAND; n++) begin
      if (o_counts[n*CNT_W +: CNT_W] == best_val && IDX_W'(n) != best_idx)
        best_tie = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < NUM_CAND; n++) tally[n] <= '0;
      total           <= '0;
      timer           <= '0;
      o_counts        <= '0;
      o_total         <= '0;
      o_winner        <= '0;
      o_tie           <= 1'b0;
      o_results_valid <= 1'b0;
      o_vote_ack      <= 1'b0;
      o_invalid       <= 1'b0;
    end else begin
      o_vote_ack <= accept;
      o_invalid  <= reject;

      if (accept) begin
        for (int n = 0; n < NUM_CAND; n++)
          if (i_candidate[n] && tally[n] != CNT_MAX) tally[n] <= tally[n] + 1'b1;
        if (total != TOT_MAX) total <= total + 1'b1;
      end

      if (enter_lockout)
        timer <= '0;
      else if (state == S_LOCKOUT && timer != TMR_END)
        timer <= timer + 1'b1;

      if (enter_finish) begin
        for (int n = 0; n < NUM_CAND; n++) o_counts[n*CNT_W +: CNT_W] <= tally[n];
        o_total <= total;
      end

      if (publish) begin
        o_winner        <= best_idx;
        o_tie           <= best_tie;
        o_results_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_voting_machine_multi.sv
// Bench for voting_machine_multi: directed scenarios plus randomized presses checked
// against a simple vote-counting model.
module tb_voting_machine_multi;
  localparam int NC = 4;
  localparam int CW = 4;
  localparam int LC = 3;
  localparam int IW = 2;
  localparam int TW = CW + IW;

  logic              clk = 1'b0;
  logic              rst;
  logic [NC-1:0]     cand;
  logic              vo;
  logic [NC*CW-1:0]  o_counts;
  logic [TW-1:0]     o_total;
  logic [IW-1:0]     o_winner;
  logic              o_tie, o_results_valid, o_vote_ack, o_invalid, green, blue;

  voting_machine_multi #(.NUM_CAND(NC), .CNT_W(CW), .LOCKOUT_CYC(LC)) dut (
    .clk(clk), .rst(rst), .i_candidate(cand), .i_voting_over(vo),
    .o_counts(o_counts), .o_total(o_total), .o_winner(o_winner), .o_tie(o_tie),
    .o_results_valid(o_results_valid), .o_vote_ack(o_vote_ack), .o_invalid(o_invalid),
    .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  int checks = 0, passes = 0, fails = 0;
  int ack_seen = 0, inv_seen = 0;
  int m_cnt [NC];
  int m_tot, m_acks, m_invs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ack_seen += int'(o_vote_ack);
    inv_seen += int'(o_invalid);
  endtask

  task automatic model_clear();
    for (int i = 0; i < NC; i++) m_cnt[i] = 0;
    m_tot = 0; m_acks = 0; m_invs = 0;
    ack_seen = 0; inv_seen = 0;
  endtask

  task automatic model_vote(input logic [NC-1:0] pat);
    if ($countones(pat) == 1) begin
      for (int i = 0; i < NC; i++)
        if (pat[i]) m_cnt[i] = (m_cnt[i] + 1 > 15) ? 15 : m_cnt[i] + 1;
      m_tot = (m_tot + 1 > 63) ? 63 : m_tot + 1;
      m_acks++;
    end else if ($countones(pat) > 1) begin
      m_invs++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; cand = '0; vo = 1'b0;
    tick(); tick();
    rst = 1'b0;
    model_clear();
  endtask

  // a press that the machine is ready for: preceded by enough idle time
  task automatic press(input logic [NC-1:0] pat, input int hold, input int gap);
    model_vote(pat);
    cand = pat;
    repeat (hold) tick();
    cand = '0;
    repeat (gap) tick();
  endtask

  task automatic finish_and_check(input string tag);
    logic [NC*CW-1:0] exp_counts;
    int best, widx, nbest;
    exp_counts = '0;
    for (int i = 0; i < NC; i++) exp_counts[i*CW +: CW] = CW'(m_cnt[i]);
    best = -1; widx = 0; nbest = 0;
    for (int i = 0; i < NC; i++) if (m_cnt[i] > best) begin best = m_cnt[i]; widx = i; end
    for (int i = 0; i < NC; i++) if (m_cnt[i] == best) nbest++;
    check({tag, "_acks"}, ack_seen, m_acks);
    check({tag, "_invs"}, inv_seen, m_invs);
    vo = 1'b1;
    tick();
    check({tag, "_blue"}, {green, blue}, 2'b01);
    check({tag, "_counts"}, o_counts, exp_counts);
    check({tag, "_total"}, o_total, m_tot);
    check({tag, "_valid_early"}, o_results_valid, 1'b0);
    tick();
    check({tag, "_valid"}, o_results_valid, 1'b1);
    check({tag, "_winner"}, o_winner, widx);
    check({tag, "_tie"}, o_tie, (nbest > 1));
    vo = 1'b0;
  endtask

  initial begin
    // reset state
    rst = 1'b1; cand = '0; vo = 1'b0;
    tick(); tick();
    check("rst_counts", o_counts, 0);
    check("rst_total", o_total, 0);
    check("rst_flags", {o_results_valid, o_vote_ack, o_invalid, o_tie, o_winner}, 0);
    check("rst_leds", {green, blue}, 2'b10);
    rst = 1'b0;
    model_clear();

    // three held presses of candidate 2
    repeat (3) press(4'b0100, 5, 5);
    check("t1_acks", ack_seen, 3);
    finish_and_check("t1");
    check("t1_counts_lit", o_counts, 16'h0300);
    check("t1_winner_lit", {o_winner, o_tie}, {2'd2, 1'b0});

    // long hold counts once; a re-press inside lockout is ignored
    do_reset();
    press(4'b0010, 20, 5);
    check("t2_hold_once", ack_seen, 1);
    model_vote(4'b0010);
    cand = 4'b0010; tick();
    check("t2_ack_latency", o_vote_ack, 1'b1);
    cand = '0; tick();
    cand = 4'b0010; tick();
    cand = '0; tick();
    check("t2_lockout_reject", ack_seen, 2);
    repeat (5) tick();
    press(4'b0010, 1, 5);
    check("t2_after_lockout", ack_seen, 3);
    finish_and_check("t2");

    // multi-button press rejected, then a clean press
    do_reset();
    model_vote(4'b0101);
    cand = 4'b0101; tick();
    check("t3_invalid_pulse", {o_invalid, o_vote_ack}, 2'b10);
    cand = '0; repeat (6) tick();
    press(4'b0001, 2, 5);
    finish_and_check("t3");
    check("t3_tally0", o_counts[3:0], 1);

    // saturation of one tally while total keeps counting
    do_reset();
    repeat (16) press(4'b0001, 1, 5);
    check("t4_acks", ack_seen, 16);
    finish_and_check("t4");
    check("t4_sat", {o_counts[3:0], o_total}, {4'd15, 6'd16});

    // ties
    do_reset();
    repeat (2) press(4'b0010, 2, 5);
    repeat (2) press(4'b1000, 2, 5);
    finish_and_check("t5a");
    check("t5a_lit", {o_winner, o_tie}, {2'd1, 1'b1});
    do_reset();
    finish_and_check("t5b");
    check("t5b_lit", {o_winner, o_tie}, {2'd0, 1'b1});

    // close of poll beats a same-cycle press; FINISH ignores inputs; reset reopens
    do_reset();
    cand = 4'b0001; vo = 1'b1; tick();
    check("t6_finish", {green, blue}, 2'b01);
    check("t6_discard", o_counts, 0);
    vo = 1'b0; cand = 4'b0001; repeat (3) tick();
    cand = '0; repeat (3) tick();
    cand = 4'b0100; repeat (3) tick();
    check("t6_frozen", {o_counts, o_total}, 0);
    check("t6_no_ack", ack_seen, 0);
    check("t6_results", {o_results_valid, o_winner, o_tie}, {1'b1, 2'd0, 1'b1});
    cand = '0; rst = 1'b1; tick(); rst = 1'b0;
    check("t6_rst_leds", {green, blue}, 2'b10);
    check("t6_rst_out", {o_counts, o_total, o_results_valid, o_winner, o_tie}, 0);
    model_clear();

    // randomized presses against the model
    for (int i = 0; i < 40; i++)
      press(NC'($urandom_range(1, 15)), $urandom_range(1, 6), $urandom_range(5, 8));
    finish_and_check("rnd");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
